// File: rtl/motor_poll_scheduler.sv
// Round-robin poll sequencer for the shared SPI motor link.
// Optional MOTOR_POLL_RETRY_EN: one retry per motor before a timeout is counted.
module motor_poll_scheduler #(
    parameter int NUMBER_OF_MOTORS = 6,
    parameter int MOTOR_BITS       = 3,
    parameter int PERIOD_CYCLES    = 50000,
    parameter int TIMEOUT_CYCLES   = 4096
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_enable,
    input  logic [NUMBER_OF_MOTORS-1:0] i_motor_enable,
    input  logic                        i_spi_done,
    output logic                        o_spi_start,
    output logic [MOTOR_BITS-1:0]       o_motor,
    output logic [NUMBER_OF_MOTORS-1:0] o_ss_sel,
    output logic                        o_update_strobe,
    output logic [MOTOR_BITS-1:0]       o_update_motor,
    output logic                        o_sweep_done,
    output logic [15:0]                 o_timeout_count,
    output logic [15:0]                 o_overrun_count
);

    localparam int PW = $clog2(PERIOD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = MOTOR_BITS + 1;
    localparam logic [PW-1:0] P_LAST = PW'(PERIOD_CYCLES - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_TICK, S_SCAN, S_START, S_BUSY, S_UPDATE
    } state_t;

    state_t                        r_state;
    logic [PW-1:0]                 r_timer;
    logic [TW-1:0]                 r_to;
    logic [SW-1:0]                 r_scan;
    logic                          r_done_d;
    logic                          r_spi_start;
    logic [MOTOR_BITS-1:0]         r_motor;
    logic [NUMBER_OF_MOTORS-1:0]   r_ss;
    logic                          r_update_strobe;
    logic [MOTOR_BITS-1:0]         r_update_motor;
    logic                          r_sweep_done;
    logic [15:0]                   r_timeout;
    logic [15:0]                   r_overrun;

    logic                          w_tick;
    logic                          w_done_rise;
    logic                          w_timeout;
    logic                          w_found;
    logic [MOTOR_BITS-1:0]         w_idx;
    logic                          w_retry;

    assign w_tick      = i_enable && (r_timer == P_LAST);
    assign w_done_rise = i_spi_done && !r_done_d;
    assign w_timeout   = (r_state == S_BUSY) && !w_done_rise && (r_to == T_LAST);

    // Scan index is one bit wider than a motor index so it can run off the end.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < NUMBER_OF_MOTORS; i++) begin
            if (!w_found && i_motor_enable[i] && (i >= int'(r_scan))) begin
                w_found = 1'b1;
                w_idx   = MOTOR_BITS'(i);
            end
        end
    end

`ifdef MOTOR_POLL_RETRY_EN
    logic r_retried;

    assign w_retry = !r_retried && i_enable;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_retried <= 1'b0;
        end else if (r_state == S_BUSY) begin
            if (w_done_rise) begin
                r_retried <= 1'b0;
            end else if (w_timeout) begin
                r_retried <= w_retry;
            end
        end
    end
`else
    assign w_retry = 1'b0;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset || !i_enable || (r_timer == P_LAST)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state         <= S_IDLE;
            r_to            <= '0;
            r_scan          <= '0;
            r_done_d        <= 1'b0;
            r_spi_start     <= 1'b0;
            r_motor         <= '0;
            r_ss            <= '0;
            r_update_strobe <= 1'b0;
            r_update_motor  <= '0;
            r_sweep_done    <= 1'b0;
            r_timeout       <= '0;
            r_overrun       <= '0;
        end else begin
            r_done_d        <= i_spi_done;
            r_spi_start     <= 1'b0;
            r_update_strobe <= 1'b0;
            r_sweep_done    <= 1'b0;
            if (w_tick && (r_state != S_IDLE) && (r_state != S_WAIT_TICK)
                && (r_overrun != 16'hFFFF)) begin
                r_overrun <= r_overrun + 16'd1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (i_enable) r_state <= S_WAIT_TICK;
                end
                S_WAIT_TICK: begin
                    if (!i_enable) begin
                        r_state <= S_IDLE;
                    end else if (w_tick) begin
                        r_scan  <= '0;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_found && i_enable) begin
                        r_motor     <= w_idx;
                        r_ss        <= NUMBER_OF_MOTORS'(1) << w_idx;
                        r_spi_start <= 1'b1;
                        r_state     <= S_START;
                    end else begin
                        r_sweep_done <= !w_found;
                        r_state      <= i_enable ? S_WAIT_TICK : S_IDLE;
                    end
                end
                S_START: begin
                    r_to    <= '0;
                    r_state <= S_BUSY;
                end
                S_BUSY: begin
                    if (w_done_rise) begin
                        r_ss            <= '0;
                        r_update_strobe <= 1'b1;
                        r_update_motor  <= r_motor;
                        r_state         <= S_UPDATE;
                    end else if (w_timeout && w_retry) begin
                        r_spi_start <= 1'b1;
                        r_state     <= S_START;
                    end else if (w_timeout) begin
                        if (r_timeout != 16'hFFFF) r_timeout <= r_timeout + 16'd1;
                        r_ss    <= '0;
                        r_scan  <= SW'(r_motor) + SW'(1);
                        r_state <= S_SCAN;
                    end else begin
                        r_to <= r_to + 1'b1;
                    end
                end
                S_UPDATE: begin
                    if (!i_enable) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_scan  <= SW'(r_motor) + SW'(1);
                        r_state <= S_SCAN;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_spi_start     = r_spi_start;
    assign o_motor         = r_motor;
    assign o_ss_sel        = r_ss;
    assign o_update_strobe = r_update_strobe;
    assign o_update_motor  = r_update_motor;
    assign o_sweep_done    = r_sweep_done;
    assign o_timeout_count = r_timeout;
    assign o_overrun_count = r_overrun;

endmodule

// File: tb/tb_motor_poll_scheduler.sv
// Scoreboard bench for motor_poll_scheduler with a behavioural SPI slave.
// Expected starts are queued by the test sequence, expected strobes by the slave.
module tb_motor_poll_scheduler;

    localparam int N  = 6;
    localparam int MB = 3;
    localparam int P  = 300;
    localparam int T  = 64;

    logic          clk;
    logic          i_reset;
    logic          i_enable;
    logic [N-1:0]  i_motor_enable;
    logic          i_spi_done;
    logic          o_spi_start;
    logic [MB-1:0] o_motor;
    logic [N-1:0]  o_ss_sel;
    logic          o_update_strobe;
    logic [MB-1:0] o_update_motor;
    logic          o_sweep_done;
    logic [15:0]   o_timeout_count;
    logic [15:0]   o_overrun_count;

    motor_poll_scheduler #(
        .NUMBER_OF_MOTORS(N),
        .MOTOR_BITS(MB),
        .PERIOD_CYCLES(P),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .i_clock(clk),
        .i_reset(i_reset),
        .i_enable(i_enable),
        .i_motor_enable(i_motor_enable),
        .i_spi_done(i_spi_done),
        .o_spi_start(o_spi_start),
        .o_motor(o_motor),
        .o_ss_sel(o_ss_sel),
        .o_update_strobe(o_update_strobe),
        .o_update_motor(o_update_motor),
        .o_sweep_done(o_sweep_done),
        .o_timeout_count(o_timeout_count),
        .o_overrun_count(o_overrun_count)
    );

    // kind: 0 no timing check, 1 gap from last strobe, 2 from last start,
    // 3 from first start of previous sweep
    typedef struct {
        int m;
        int kind;
        int gap;
    } start_t;

    typedef struct {
        int m;
        int cyc;
    } strobe_t;

    start_t  exp_start[$];
    strobe_t exp_strobe[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int lat = 20;
    int silent[N];
    int sweeps_rst = 0;
    int start_cnt = 0;
    int strobe_cnt = 0;
    int last_start = 0;
    int last_strobe = 0;
    int first_start = 0;
    bit new_sweep = 1'b1;
    bit ovr_mode = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic push_start(input int m, input int kind, input int gap);
        start_t s;
        s.m = m;
        s.kind = kind;
        s.gap = gap;
        exp_start.push_back(s);
    endtask

    task automatic push_sweep(input logic [N-1:0] mask, input int k0,
                              input int g0);
        bit first = 1'b1;
        for (int m = 0; m < N; m++) begin
            if (mask[m]) begin
                if (first) push_start(m, k0, g0);
                else push_start(m, 1, 2);
                first = 1'b0;
            end
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_start"}, o_spi_start, 0);
        check_eq({tag, "_motor"}, o_motor, 0);
        check_eq({tag, "_ss"}, o_ss_sel, 0);
        check_eq({tag, "_strobe"}, o_update_strobe, 0);
        check_eq({tag, "_umotor"}, o_update_motor, 0);
        check_eq({tag, "_sweep"}, o_sweep_done, 0);
        check_eq({tag, "_tocnt"}, o_timeout_count, 0);
        check_eq({tag, "_ovcnt"}, o_overrun_count, 0);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_enable = 1'b0;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
    endtask

    task automatic wait_sweeps(input int n, input int budget);
        int t = 0;
        while (sweeps_rst < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check_eq("sweep_wait", sweeps_rst, n);
    endtask

    task automatic wait_starts(input int n, input int budget);
        int t = 0;
        while (start_cnt < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check_eq("start_wait", start_cnt, n);
    endtask

    task automatic drain(input string tag);
        i_enable = 1'b0;
        repeat (80) @(negedge clk);
        check_eq({tag, "_startq"}, exp_start.size(), 0);
        check_eq({tag, "_strobeq"}, exp_strobe.size(), 0);
        exp_start.delete();
        exp_strobe.delete();
    endtask

    // SPI slave model: answers each start after lat cycles unless silenced
    initial begin
        int  m;
        bit  abort;
        strobe_t s;
        i_spi_done = 1'b0;
        forever begin
            @(negedge clk);
            if (o_spi_start && !i_reset) begin
                m = int'(o_motor);
                if (silent[m] != 0) begin
                    if (silent[m] > 0) silent[m]--;
                end else begin
                    abort = 1'b0;
                    for (int k = 0; k < lat; k++) begin
                        @(negedge clk);
                        if (i_reset) abort = 1'b1;
                    end
                    if (!abort && !i_reset) begin
                        s.m = m;
                        s.cyc = cyc + 1;
                        exp_strobe.push_back(s);
                        i_spi_done = 1'b1;
                        repeat (2) @(negedge clk);
                        i_spi_done = 1'b0;
                    end
                end
            end
        end
    end

    // Output monitor
    initial begin
        start_t  se;
        strobe_t so;
        forever begin
            @(negedge clk);
            if (i_reset) begin
                sweeps_rst = 0;
                new_sweep = 1'b1;
            end else begin
                if (o_spi_start) begin
                    start_cnt++;
                    if (exp_start.size() == 0) begin
                        check_eq("start_unexpected", o_spi_start, 0);
                    end else begin
                        se = exp_start.pop_front();
                        check_eq("start_motor", o_motor, se.m);
                        check_eq("start_ss_sel", o_ss_sel, 32'd1 << se.m);
                        if (se.kind == 1)
                            check_eq("gap_strobe_start", cyc - last_strobe, se.gap);
                        else if (se.kind == 2)
                            check_eq("gap_start_start", cyc - last_start, se.gap);
                        else if (se.kind == 3)
                            check_eq("gap_sweep", cyc - first_start, se.gap);
                    end
                    if (new_sweep) begin
                        first_start = cyc;
                        new_sweep = 1'b0;
                    end
                    last_start = cyc;
                end
                if (o_update_strobe) begin
                    strobe_cnt++;
                    check_eq("strobe_ss_clear", o_ss_sel, 0);
                    if (exp_strobe.size() == 0) begin
                        check_eq("strobe_unexpected", o_update_strobe, 0);
                    end else begin
                        so = exp_strobe.pop_front();
                        check_eq("strobe_motor", o_update_motor, so.m);
                        check_eq("strobe_latency", cyc, so.cyc);
                    end
                    last_strobe = cyc;
                end
                if (o_sweep_done) begin
                    sweeps_rst++;
                    new_sweep = 1'b1;
                    check_eq("overrun", o_overrun_count, ovr_mode ? sweeps_rst : 0);
                end
            end
        end
    end

    initial begin
        int base;
        for (int m = 0; m < N; m++) silent[m] = 0;
        i_reset = 1'b1;
        i_enable = 1'b0;
        i_motor_enable = '0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        i_reset = 1'b0;

        // full mask, two sweeps one period apart
        lat = 20;
        i_motor_enable = 6'b111111;
        push_sweep(6'b111111, 0, 0);
        push_sweep(6'b111111, 3, P);
        i_enable = 1'b1;
        wait_sweeps(2, 1500);
        check_eq("t1_timeouts", o_timeout_count, 0);
        drain("t1");

        // sparse mask
        do_reset();
        i_motor_enable = 6'b100101;
        push_sweep(6'b100101, 0, 0);
        base = strobe_cnt;
        i_enable = 1'b1;
        wait_sweeps(1, 1000);
        check_eq("t2_strobes", strobe_cnt - base, 3);
        drain("t2");

        // motor 3 never answers
        do_reset();
        silent[3] = -1;
        i_motor_enable = 6'b111111;
        push_start(0, 0, 0);
        push_start(1, 1, 2);
        push_start(2, 1, 2);
        push_start(3, 1, 2);
`ifdef MOTOR_POLL_RETRY_EN
        push_start(3, 2, T + 1);
`endif
        push_start(4, 2, T + 2);
        push_start(5, 1, 2);
        base = strobe_cnt;
        i_enable = 1'b1;
        wait_sweeps(1, 1200);
        check_eq("t3_timeouts", o_timeout_count, 1);
        check_eq("t3_strobes", strobe_cnt - base, 5);
        drain("t3");
        silent[3] = 0;

        // sweep longer than the period: one dropped tick per sweep
        do_reset();
        lat = 60;
        ovr_mode = 1'b1;
        push_sweep(6'b111111, 0, 0);
        push_sweep(6'b111111, 3, 2 * P);
        push_sweep(6'b111111, 3, 2 * P);
        i_enable = 1'b1;
        wait_sweeps(3, 2500);
        check_eq("t4_overrun", o_overrun_count, 3);
        drain("t4");
        ovr_mode = 1'b0;

        // enable drops while motor 2 is busy
        do_reset();
        lat = 20;
        push_start(0, 0, 0);
        push_start(1, 1, 2);
        push_start(2, 1, 2);
        base = strobe_cnt;
        i_enable = 1'b1;
        wait_starts(start_cnt + 3, 800);
        repeat (5) @(negedge clk);
        i_enable = 1'b0;
        repeat (60) @(negedge clk);
        check_eq("t5_strobes", strobe_cnt - base, 3);
        check_eq("t5_ss_idle", o_ss_sel, 0);
        check_eq("t5_sweeps", sweeps_rst, 0);
        drain("t5");

        // reset while busy
        push_start(0, 0, 0);
        i_enable = 1'b1;
        wait_starts(start_cnt + 1, 800);
        repeat (5) @(negedge clk);
        i_reset = 1'b1;
        i_enable = 1'b0;
        @(negedge clk);
        check_quiet("rst_busy");
        @(negedge clk);
        i_reset = 1'b0;
        drain("t5r");

`ifdef MOTOR_POLL_RETRY_EN
        // motor 1 silent once, then answers on the retry
        do_reset();
        silent[1] = 1;
        push_start(0, 0, 0);
        push_start(1, 1, 2);
        push_start(1, 2, T + 1);
        for (int m = 2; m < N; m++) push_start(m, 1, 2);
        base = strobe_cnt;
        i_enable = 1'b1;
        wait_sweeps(1, 1200);
        check_eq("t6_timeouts", o_timeout_count, 0);
        check_eq("t6_strobes", strobe_cnt - base, 6);
        drain("t6");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
